// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register controller.
package spi_pkg;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } spi_state_e;

    // Command byte layout: read flag on top, start address below it.
    localparam int CMD_READ_BIT = 7;
    localparam int CMD_ADDR_W   = 7;

    // True when a 7-bit bus address maps onto an implemented register.
    function automatic logic addr_in_range(input logic [CMD_ADDR_W-1:0] addr, input int num_regs);
        return int'(addr) < num_regs;
    endfunction

endpackage

// File: rtl/spi_regbank.sv
// Register bank with an SPI port and a fabric port; SPI writes win on collision.
import spi_pkg::*;

module spi_regbank #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_spi_we,
    input  logic [CMD_ADDR_W-1:0] i_spi_addr,
    input  logic [7:0]            i_spi_wdata,
    output logic [7:0]            o_spi_rdata,
    output logic                  o_spi_in_range,
    input  logic                  i_host_we,
    input  logic [ADDR_W-1:0]     i_host_addr,
    input  logic [7:0]            i_host_wdata,
    output logic [7:0]            o_host_rdata
);

    // Flat view of every register, used by both read muxes.
    logic [NUM_REGS*8-1:0] regs_flat;
    logic                  host_in_range;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic       spi_hit;
        logic       host_hit;
        logic [7:0] reg_q;

        assign spi_hit  = i_spi_we && (i_spi_addr == CMD_ADDR_W'(gi));
        assign host_hit = i_host_we && (i_host_addr == ADDR_W'(gi));

        // One storage byte; the SPI port takes priority over the host port.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                reg_q <= 8'h00;
            end else if (spi_hit) begin
                reg_q <= i_spi_wdata;
            end else if (host_hit) begin
                reg_q <= i_host_wdata;
            end
        end

        assign regs_flat[gi*8 +: 8] = reg_q;
    end

    assign o_spi_in_range = addr_in_range(i_spi_addr, NUM_REGS);
    assign host_in_range  = int'(i_host_addr) < NUM_REGS;

    // Combinational read muxes; unimplemented addresses read as zero.
    always_comb begin
        o_spi_rdata  = 8'h00;
        o_host_rdata = 8'h00;
        if (o_spi_in_range) begin
            o_spi_rdata = regs_flat[int'(i_spi_addr)*8 +: 8];
        end
        if (host_in_range) begin
            o_host_rdata = regs_flat[int'(i_host_addr)*8 +: 8];
        end
    end

endmodule

// File: rtl/spi_register_controller.sv
// Turns SPI chip-select frames into register-bank reads and writes.
import spi_pkg::*;

module spi_register_controller #(
    parameter  int         NUM_REGS    = 16,
    parameter  logic [7:0] STATUS_BYTE = 8'hA5,
    localparam int         ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [7:0]        i_rx_byte,
    input  logic              i_rx_dv,
    input  logic              i_spi_active,
    output logic [7:0]        o_tx_byte,
    output logic              o_tx_dv,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [7:0]        i_host_wdata,
    output logic [7:0]        o_host_rdata,
    output logic              o_spi_wr_strobe,
    output logic [6:0]        o_spi_wr_addr,
    output logic              o_error
);

    spi_state_e            state_q, state_d;
    logic [CMD_ADDR_W-1:0] addr_q, addr_d;
    logic                  active_q;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic                  tx_dv_q, tx_dv_d;
    logic                  wr_strobe_q, wr_strobe_d;
    logic [6:0]            wr_addr_q, wr_addr_d;
    logic                  error_q, error_d;

    logic                  spi_we;
    logic [CMD_ADDR_W-1:0] spi_addr;
    logic [7:0]            spi_rdata;
    logic                  spi_in_range;

    spi_regbank #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_regbank (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_spi_we       (spi_we),
        .i_spi_addr     (spi_addr),
        .i_spi_wdata    (i_rx_byte),
        .o_spi_rdata    (spi_rdata),
        .o_spi_in_range (spi_in_range),
        .i_host_we      (i_host_we),
        .i_host_addr    (i_host_addr),
        .i_host_wdata   (i_host_wdata),
        .o_host_rdata   (o_host_rdata)
    );

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            active_q    <= 1'b0;
            tx_byte_q   <= 8'h00;
            tx_dv_q     <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 7'd0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            active_q    <= i_spi_active;
            tx_byte_q   <= tx_byte_d;
            tx_dv_q     <= tx_dv_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            error_q     <= error_d;
        end
    end

    // Frame sequencing: command parse, then streaming writes or reads.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tx_byte_d   = tx_byte_q;
        tx_dv_d     = 1'b0;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        error_d     = error_q;
        spi_we      = 1'b0;
        // The command byte itself carries the first read address.
        spi_addr    = (state_q == CMD) ? i_rx_byte[CMD_ADDR_W-1:0] : addr_q;

        if (!i_spi_active) begin
            state_d = IDLE;
        end else if (!active_q) begin
            // Status byte goes out while the command byte is shifting in.
            state_d   = CMD;
            tx_byte_d = STATUS_BYTE;
            tx_dv_d   = 1'b1;
        end else if (i_rx_dv) begin
            unique case (state_q)
                CMD: begin
                    if (i_rx_byte[CMD_READ_BIT]) begin
                        state_d   = READ;
                        tx_byte_d = spi_rdata;
                        tx_dv_d   = 1'b1;
                        addr_d    = spi_addr + 7'd1;
                        if (!spi_in_range) error_d = 1'b1;
                    end else begin
                        state_d = WRITE;
                        addr_d  = spi_addr;
                    end
                end
                WRITE: begin
                    if (spi_in_range) begin
                        spi_we      = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = addr_q;
                    end else begin
                        error_d = 1'b1;
                    end
                    addr_d = addr_q + 7'd1;
                end
                READ: begin
                    tx_byte_d = spi_rdata;
                    tx_dv_d   = 1'b1;
                    addr_d    = addr_q + 7'd1;
                    if (!spi_in_range) error_d = 1'b1;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    assign o_tx_byte       = tx_byte_q;
    assign o_tx_dv         = tx_dv_q;
    assign o_spi_wr_strobe = wr_strobe_q;
    assign o_spi_wr_addr   = wr_addr_q;
    assign o_error         = error_q;

endmodule

// File: tb/tb_spi_register_controller.sv
// Randomized bench for spi_register_controller with a frame-level reference model.
module tb_spi_register_controller;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_byte = 8'h00;
    logic              rx_dv = 1'b0;
    logic              spi_active = 1'b0;
    logic              host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [7:0]        host_wdata = 8'h00;
    logic [7:0]        o_tx_byte;
    logic              o_tx_dv;
    logic [7:0]        o_host_rdata;
    logic              o_spi_wr_strobe;
    logic [6:0]        o_spi_wr_addr;
    logic              o_error;

    always #5 clk = ~clk;

    spi_register_controller #(
        .NUM_REGS    (NUM_REGS),
        .STATUS_BYTE (8'hA5)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_rx_byte       (rx_byte),
        .i_rx_dv         (rx_dv),
        .i_spi_active    (spi_active),
        .o_tx_byte       (o_tx_byte),
        .o_tx_dv         (o_tx_dv),
        .i_host_we       (host_we),
        .i_host_addr     (host_addr),
        .i_host_wdata    (host_wdata),
        .o_host_rdata    (o_host_rdata),
        .o_spi_wr_strobe (o_spi_wr_strobe),
        .o_spi_wr_addr   (o_spi_wr_addr),
        .o_error         (o_error)
    );

    int checks = 0;
    int errors = 0;
    bit rnd_host = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    logic [7:0] m_regs [128];
    bit         m_prev_act, m_in_frame, m_have_cmd, m_rd;
    logic [6:0] m_ptr;
    bit         spi_wr;
    logic [6:0] spi_wr_a;
    bit         e_tx_dv, e_str, e_err;
    logic [7:0] e_tx_byte;
    logic [6:0] e_str_addr;

    task automatic model_read();
        e_tx_byte = (int'(m_ptr) < NUM_REGS) ? m_regs[m_ptr] : 8'h00;
        if (int'(m_ptr) >= NUM_REGS) e_err = 1'b1;
        e_tx_dv = 1'b1;
        m_ptr   = m_ptr + 7'd1;
    endtask

    task automatic model_step();
        if (rst) begin
            for (int i = 0; i < 128; i++) m_regs[i] = 8'h00;
            m_prev_act = 0; m_in_frame = 0; m_have_cmd = 0; m_rd = 0; m_ptr = '0;
            e_tx_dv = 0; e_tx_byte = 8'h00; e_str = 0; e_str_addr = '0; e_err = 0;
            return;
        end
        e_tx_dv = 0;
        e_str   = 0;
        spi_wr  = 0;
        if (!spi_active) begin
            m_in_frame = 0;
        end else if (!m_prev_act) begin
            e_tx_byte  = 8'hA5;
            e_tx_dv    = 1;
            m_in_frame = 1;
            m_have_cmd = 0;
        end else if (m_in_frame && rx_dv) begin
            if (!m_have_cmd) begin
                m_have_cmd = 1;
                m_rd       = rx_byte[7];
                m_ptr      = rx_byte[6:0];
                if (m_rd) model_read();
            end else if (m_rd) begin
                model_read();
            end else begin
                if (int'(m_ptr) < NUM_REGS) begin
                    spi_wr = 1; spi_wr_a = m_ptr; e_str = 1; e_str_addr = m_ptr;
                end else begin
                    e_err = 1;
                end
                m_ptr = m_ptr + 7'd1;
            end
        end
        if (host_we && !(spi_wr && spi_wr_a == 7'(host_addr)) && int'(host_addr) < NUM_REGS)
            m_regs[host_addr] = host_wdata;
        if (spi_wr) m_regs[spi_wr_a] = rx_byte;
        m_prev_act = spi_active;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // ---------------- per-cycle compare and logging ----------------
    logic [7:0] tx_log [$];
    logic [6:0] str_log [$];

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("tx_dv", 32'(o_tx_dv), 32'(e_tx_dv));
            if (e_tx_dv) chk("tx_byte", 32'(o_tx_byte), 32'(e_tx_byte));
            chk("wr_strobe", 32'(o_spi_wr_strobe), 32'(e_str));
            if (e_str) chk("wr_addr", 32'(o_spi_wr_addr), 32'(e_str_addr));
            chk("error", 32'(o_error), 32'(e_err));
            chk("host_rdata", 32'(o_host_rdata),
                32'((int'(host_addr) < NUM_REGS) ? m_regs[host_addr] : 8'h00));
            if (o_tx_dv) tx_log.push_back(o_tx_byte);
            if (o_spi_wr_strobe) str_log.push_back(o_spi_wr_addr);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_host) begin
                host_we    = 1'($urandom_range(0, 1));
                host_addr  = ADDR_W'($urandom_range(0, NUM_REGS - 1));
                host_wdata = 8'($urandom);
            end
        end
    endtask

    task automatic start_frame();
        spi_active = 1'b1;
        tick(2);
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte = b;
        rx_dv   = 1'b1;
        tick(1);
        rx_dv = 1'b0;
        tick($urandom_range(2, 5));
    endtask

    task automatic end_frame();
        spi_active = 1'b0;
        tick(2);
    endtask

    task automatic peek(input string name, input int addr, input logic [7:0] exp);
        host_addr = ADDR_W'(addr);
        #1;
        chk(name, 32'(o_host_rdata), 32'(exp));
    endtask

    task automatic clear_logs();
        tx_log.delete();
        str_log.delete();
    endtask

    initial begin
        logic [7:0] cmd;
        int         nbytes;

        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_tx_dv", 32'(o_tx_dv), 0);
        chk("rst_tx_byte", 32'(o_tx_byte), 0);
        chk("rst_strobe", 32'(o_spi_wr_strobe), 0);
        chk("rst_wr_addr", 32'(o_spi_wr_addr), 0);
        chk("rst_error", 32'(o_error), 0);

        // Frame start produces a single status-byte pulse.
        spi_active = 1'b1;
        tick(1);
        chk("start_tx_dv", 32'(o_tx_dv), 1);
        chk("start_tx_byte", 32'(o_tx_byte), 32'h A5);
        tick(1);
        chk("start_tx_dv_single", 32'(o_tx_dv), 0);
        for (int i = 0; i < NUM_REGS; i++) peek("rst_reg", i, 8'h00);
        end_frame();

        // SPI write burst.
        clear_logs();
        start_frame();
        send(8'h03); send(8'h11); send(8'h22);
        end_frame();
        peek("wr_reg3", 3, 8'h11);
        peek("wr_reg4", 4, 8'h22);
        chk("wr_strobe_count", 32'(str_log.size()), 2);
        chk("wr_strobe_a0", (str_log.size() > 0) ? 32'(str_log[0]) : 32'hFFFF, 3);
        chk("wr_strobe_a1", (str_log.size() > 1) ? 32'(str_log[1]) : 32'hFFFF, 4);
        chk("wr_no_error", 32'(o_error), 0);

        // Host write followed by SPI read burst.
        host_we = 1'b1; host_addr = 4'd5; host_wdata = 8'h5C;
        tick(1);
        host_we = 1'b0;
        clear_logs();
        start_frame();
        send(8'h85); send(8'h00); send(8'h00);
        end_frame();
        chk("rd_tx_count", 32'(tx_log.size()), 4);
        chk("rd_tx0", (tx_log.size() > 0) ? 32'(tx_log[0]) : 32'hFFFF, 32'hA5);
        chk("rd_tx1", (tx_log.size() > 1) ? 32'(tx_log[1]) : 32'hFFFF, 32'h5C);
        chk("rd_tx2", (tx_log.size() > 2) ? 32'(tx_log[2]) : 32'hFFFF, 32'h00);

        // Write running off the end of the bank.
        clear_logs();
        start_frame();
        send(8'h0F); send(8'hAA); send(8'hBB);
        end_frame();
        peek("oor_reg15", 15, 8'hAA);
        chk("oor_error", 32'(o_error), 1);
        chk("oor_strobe_count", 32'(str_log.size()), 1);

        // Same-cycle SPI and host write to one register.
        start_frame();
        send(8'h02);
        rx_byte = 8'h77; rx_dv = 1'b1;
        host_we = 1'b1; host_addr = 4'd2; host_wdata = 8'h33;
        tick(1);
        rx_dv = 1'b0; host_we = 1'b0;
        tick(3);
        end_frame();
        peek("collide_reg2", 2, 8'h77);

        // Stray byte after frame end is ignored.
        clear_logs();
        start_frame();
        send(8'h0A);
        end_frame();
        rx_byte = 8'h99; rx_dv = 1'b1;
        tick(1);
        rx_dv = 1'b0;
        tick(2);
        peek("stray_reg10", 10, 8'h00);
        chk("stray_no_strobe", 32'(str_log.size()), 0);

        // Reset in the middle of a write frame.
        start_frame();
        send(8'h00); send(8'h12);
        rst = 1'b1;
        tick(2);
        spi_active = 1'b0;
        rst = 1'b0;
        tick(2);
        for (int i = 0; i < NUM_REGS; i++) peek("midrst_reg", i, 8'h00);
        chk("midrst_error", 32'(o_error), 0);
        chk("midrst_tx_dv", 32'(o_tx_dv), 0);

        // Randomized frames with concurrent host traffic.
        rnd_host = 1'b1;
        for (int f = 0; f < 30; f++) begin
            case ($urandom_range(0, 3))
                0:       cmd = 8'($urandom);
                1:       cmd = {1'($urandom_range(0, 1)), 7'h7E};
                default: cmd = {1'($urandom_range(0, 1)), 7'($urandom_range(0, NUM_REGS + 2))};
            endcase
            nbytes = $urandom_range(0, 5);
            start_frame();
            send(cmd);
            for (int b = 0; b < nbytes; b++) send(8'($urandom));
            end_frame();
        end
        rnd_host = 1'b0;
        host_we  = 1'b0;
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
